// File: rtl/load_store_unit_if.sv
// MMU-side bus of the load/store unit. The LSU is the master: it drives the
// word address, lane-replicated write data, read/write strobes and byte
// enables. The MMU drives back its completion flag and the read word.
interface load_store_unit_if;
    logic [31:0] mmu_addr;
    logic [31:0] mmu_datain;
    logic        mmu_ren;
    logic        mmu_wen;
    logic [3:0]  mmu_byte_sel;
    logic        mmu_nostall;
    logic [31:0] mmu_dataout;

    modport master (
        output mmu_addr,
        output mmu_datain,
        output mmu_ren,
        output mmu_wen,
        output mmu_byte_sel,
        input  mmu_nostall,
        input  mmu_dataout
    );

    modport slave (
        input  mmu_addr,
        input  mmu_datain,
        input  mmu_ren,
        input  mmu_wen,
        input  mmu_byte_sel,
        output mmu_nostall,
        output mmu_dataout
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the MEM stage and the MMU.
// A legal request is latched in IDLE and then replayed to the MMU from the
// latched copy, so the pipeline inputs may wander during ACCESS. Alignment
// and funct3 errors are reported in the request cycle without touching the
// MMU. A watchdog turns a stuck MMU access into an access-fault exception.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        exc_valid,
    output logic [3:0]  exc_cause,
    output logic [31:0] exc_addr,
    load_store_unit_if.master mmu
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

    state_t      state_reg;
    logic [31:0] addr_reg;
    logic [2:0]  funct3_reg;
    logic        is_store_reg;
    logic        fault_reg;
    logic [31:0] timeout_count_reg;
    logic [31:0] mmu_addr_reg;
    logic [31:0] mmu_datain_reg;
    logic [3:0]  byte_sel_reg;
    logic        ren_reg;
    logic        wen_reg;
    logic [31:0] load_data_reg;

    logic        req;
    logic        funct3_legal;
    logic        misaligned;
    logic        req_accept;
    logic        req_exc;
    logic [3:0]  req_cause;
    logic [3:0]  req_byte_sel;
    logic [31:0] req_datain;
    logic [31:0] shifted_word;
    logic [31:0] extracted;
    logic        watchdog_expired;

    // Store data replicated onto every byte lane so the MMU can pick any lane.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign req_datain[8*gi +: 8] =
                !mem_write            ? 8'h00 :
                (funct3[1:0] == 2'b00) ? store_data[7:0] :
                (funct3[1:0] == 2'b01) ? store_data[8*(gi % 2) +: 8] :
                                         store_data[8*gi +: 8];
        end
    endgenerate

    // Decode and validate the request presented by the MEM stage.
    always_comb begin
        req = mem_valid & (mem_read | mem_write);
        // Stores allow only B/H/W; loads additionally allow BU/HU.
        if (mem_write) begin
            funct3_legal = !funct3[2] && (funct3[1:0] != 2'b11);
        end else begin
            funct3_legal = (funct3[1:0] != 2'b11) && (funct3 != 3'b110);
        end
        case (funct3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00:   req_byte_sel = 4'b0001 << addr[1:0];
            2'b01:   req_byte_sel = 4'b0011 << addr[1:0];
            default: req_byte_sel = 4'b1111;
        endcase
        req_exc    = (state_reg == IDLE) && req && (!funct3_legal || misaligned);
        req_accept = (state_reg == IDLE) && req && funct3_legal && !misaligned;
        if (mem_write) begin
            req_cause = funct3_legal ? CAUSE_ST_MISALIGN : CAUSE_ST_FAULT;
        end else begin
            req_cause = funct3_legal ? CAUSE_LD_MISALIGN : CAUSE_LD_FAULT;
        end
    end

    // Align the returned word to the addressed byte and extend to 32 bits.
    always_comb begin
        shifted_word = mmu.mmu_dataout >> {addr_reg[1:0], 3'b000};
        case (funct3_reg)
            3'b000:  extracted = {{24{shifted_word[7]}}, shifted_word[7:0]};
            3'b001:  extracted = {{16{shifted_word[15]}}, shifted_word[15:0]};
            3'b100:  extracted = {24'h000000, shifted_word[7:0]};
            3'b101:  extracted = {16'h0000, shifted_word[15:0]};
            default: extracted = shifted_word;
        endcase
        // A nostall on the final watchdog cycle still counts as success.
        watchdog_expired = (TIMEOUT_CYCLES != 0) &&
                           (timeout_count_reg == 32'(TIMEOUT_CYCLES - 1));
    end

    // Request/access/retire sequencer with registered MMU strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            funct3_reg        <= '0;
            is_store_reg      <= 1'b0;
            fault_reg         <= 1'b0;
            timeout_count_reg <= '0;
            mmu_addr_reg      <= '0;
            mmu_datain_reg    <= '0;
            byte_sel_reg      <= '0;
            ren_reg           <= 1'b0;
            wen_reg           <= 1'b0;
            load_data_reg     <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_accept) begin
                        addr_reg          <= addr;
                        funct3_reg        <= funct3;
                        is_store_reg      <= mem_write;
                        fault_reg         <= 1'b0;
                        timeout_count_reg <= '0;
                        mmu_addr_reg      <= {addr[31:2], 2'b00};
                        mmu_datain_reg    <= req_datain;
                        byte_sel_reg      <= req_byte_sel;
                        ren_reg           <= !mem_write;
                        wen_reg           <= mem_write;
                        state_reg         <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (mmu.mmu_nostall) begin
                        if (!is_store_reg) begin
                            load_data_reg <= extracted;
                        end
                        ren_reg   <= 1'b0;
                        wen_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else if (watchdog_expired) begin
                        fault_reg <= 1'b1;
                        ren_reg   <= 1'b0;
                        wen_reg   <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        timeout_count_reg <= timeout_count_reg + 32'd1;
                    end
                end
                DONE: begin
                    // Any mem_valid seen here belongs to the retiring op.
                    timeout_count_reg <= '0;
                    state_reg         <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Pipeline-facing status and exception reporting.
    always_comb begin
        lsu_stall  = req_accept || (state_reg == ACCESS);
        load_valid = (state_reg == DONE) && !is_store_reg && !fault_reg;
        load_data  = load_data_reg;
        exc_valid  = 1'b0;
        exc_cause  = 4'd0;
        exc_addr   = 32'd0;
        if (req_exc) begin
            exc_valid = 1'b1;
            exc_cause = req_cause;
            exc_addr  = addr;
        end else if ((state_reg == DONE) && fault_reg) begin
            exc_valid = 1'b1;
            exc_cause = is_store_reg ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
            exc_addr  = addr_reg;
        end
        mmu.mmu_addr     = mmu_addr_reg;
        mmu.mmu_datain   = mmu_datain_reg;
        mmu.mmu_byte_sel = byte_sel_reg;
        mmu.mmu_ren      = ren_reg;
        mmu.mmu_wen      = wen_reg;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Each operation is expanded by a
// transaction-level model into per-cycle expectations; one compare process
// checks the DUT against them on every falling edge. Literal checks after
// selected operations pin the model to hand-computed values.
module tb_load_store_unit;
    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        lsu_stall;
    logic        load_valid;
    logic [31:0] load_data;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_addr;

    load_store_unit_if mmu_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .lsu_stall  (lsu_stall),
        .load_valid (load_valid),
        .load_data  (load_data),
        .exc_valid  (exc_valid),
        .exc_cause  (exc_cause),
        .exc_addr   (exc_addr),
        .mmu        (mmu_bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Per-cycle expectations written by the driver.
    bit          chk_en = 1'b0;
    bit          chk_mmu = 1'b0;
    bit          chk_din = 1'b0;
    bit          exp_stall, exp_lv, exp_exc, exp_ren, exp_wen;
    logic [3:0]  exp_cause;
    logic [31:0] exp_exc_addr, exp_load_data, exp_mmu_addr, exp_din;
    logic [3:0]  exp_bsel;
    logic [31:0] last_load = 32'd0;

    // Observations used by the literal checks.
    int          stall_count, lv_cyc, req_cyc;
    bit          seen_ren, seen_wen;
    logic [3:0]  seen_bsel, seen_cause;
    logic [31:0] seen_din, seen_exc_addr;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The compare process: every cycle while enabled.
    always @(negedge clk) begin
        if (lsu_stall) stall_count++;
        if (load_valid) lv_cyc = cyc;
        if (mmu_bus.mmu_ren) seen_ren = 1'b1;
        if (mmu_bus.mmu_wen) seen_wen = 1'b1;
        if (mmu_bus.mmu_ren || mmu_bus.mmu_wen) begin
            seen_bsel = mmu_bus.mmu_byte_sel;
            seen_din  = mmu_bus.mmu_datain;
        end
        if (exc_valid) begin
            seen_cause    = exc_cause;
            seen_exc_addr = exc_addr;
        end
        if (chk_en) begin
            check("lsu_stall", 32'(lsu_stall), 32'(exp_stall));
            check("load_valid", 32'(load_valid), 32'(exp_lv));
            check("exc_valid", 32'(exc_valid), 32'(exp_exc));
            check("mmu_ren", 32'(mmu_bus.mmu_ren), 32'(exp_ren));
            check("mmu_wen", 32'(mmu_bus.mmu_wen), 32'(exp_wen));
            check("load_data", load_data, exp_load_data);
            if (exp_exc) begin
                check("exc_cause", 32'(exc_cause), 32'(exp_cause));
                check("exc_addr", exc_addr, exp_exc_addr);
            end
            if (chk_mmu) begin
                check("mmu_addr", mmu_bus.mmu_addr, exp_mmu_addr);
                check("mmu_byte_sel", 32'(mmu_bus.mmu_byte_sel), 32'(exp_bsel));
            end
            if (chk_din) check("mmu_datain", mmu_bus.mmu_datain, exp_din);
        end
    end

    task automatic set_quiet();
        exp_stall = 0; exp_lv = 0; exp_exc = 0; exp_ren = 0; exp_wen = 0;
        exp_cause = 0; exp_exc_addr = 0; chk_mmu = 0; chk_din = 0;
        exp_load_data = last_load;
    endtask

    task automatic clear_obs();
        stall_count = 0; lv_cyc = -1; seen_ren = 0; seen_wen = 0;
        seen_bsel = 0; seen_cause = 0; seen_din = 0; seen_exc_addr = 0;
    endtask

    // One memory operation. delay = ACCESS cycle (1-based) in which the MMU
    // answers; anything outside 1..T means the MMU never answers.
    task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input int delay, input logic [31:0] word);
        int size, n;
        bit legal, mis, fault;
        logic [31:0] ext, mask, din;
        logic [3:0] bsel;
        size  = 1 << f3[1:0];
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        mis   = legal && ((a % size) != 0);
        bsel  = 4'(((1 << size) - 1) << (a % 4));
        for (int b = 0; b < 4; b++) din[8*b +: 8] = sd[8*(b % size) +: 8];
        ext = word >> (8 * (a % 4));
        if (size < 4) begin
            mask = (32'd1 << (8 * size)) - 32'd1;
            ext  = ext & mask;
            if (!f3[2] && ext[8*size-1]) ext = ext | ~mask;
        end

        clear_obs();
        @(posedge clk); #1;
        req_cyc = cyc;
        mem_valid = 1; mem_read = !st; mem_write = st; funct3 = f3; addr = a; store_data = sd;
        set_quiet();
        if (!legal || mis) begin
            exp_exc = 1;
            exp_cause = st ? (legal ? 4'd6 : 4'd7) : (legal ? 4'd4 : 4'd5);
            exp_exc_addr = a;
            @(posedge clk); #1;
            mem_valid = 0; set_quiet();
            return;
        end
        exp_stall = 1;
        fault = !(delay >= 1 && delay <= T);
        n = fault ? T : delay;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            // Request is latched; wandering inputs must not matter.
            addr = $urandom; store_data = $urandom; funct3 = 3'($urandom_range(0, 7));
            mmu_bus.mmu_nostall = (c == delay);
            mmu_bus.mmu_dataout = (c == delay) ? word : $urandom;
            set_quiet();
            exp_stall = 1; exp_ren = !st; exp_wen = st;
            chk_mmu = 1; exp_mmu_addr = {a[31:2], 2'b00}; exp_bsel = bsel;
            chk_din = st; exp_din = din;
        end
        @(posedge clk); #1;
        mmu_bus.mmu_nostall = 0; mmu_bus.mmu_dataout = $urandom;
        if (!st && !fault) last_load = ext;
        set_quiet();
        exp_lv = !st && !fault;
        exp_exc = fault;
        exp_cause = st ? 4'd7 : 4'd5;
        exp_exc_addr = a;
        @(posedge clk); #1;
        mem_valid = 0; mem_read = 0; mem_write = 0;
        set_quiet();
    endtask

    initial begin
        mmu_bus.mmu_nostall = 0;
        mmu_bus.mmu_dataout = 0;
        #3;
        check("rst_stall", 32'(lsu_stall), 0);
        check("rst_ren_wen", {30'd0, mmu_bus.mmu_ren, mmu_bus.mmu_wen}, 0);
        check("rst_load_data", load_data, 0);
        check("rst_exc", {27'd0, exc_valid, exc_cause}, 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        set_quiet();
        chk_en = 1;

        // LW 0x100: byte_sel 1111, load_valid two cycles after request.
        run_op(1'b0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF);
        check("lit_lw_data", load_data, 32'hDEADBEEF);
        check("lit_lw_bsel", 32'(seen_bsel), 32'h0000000F);
        check("lit_lw_latency", lv_cyc - req_cyc, 2);
        // LB / LBU 0x103.
        run_op(1'b0, 3'b000, 32'h103, 0, 1, 32'h80112233);
        check("lit_lb_data", load_data, 32'hFFFFFF80);
        check("lit_lb_bsel", 32'(seen_bsel), 32'h00000008);
        run_op(1'b0, 3'b100, 32'h103, 0, 1, 32'h80112233);
        check("lit_lbu_data", load_data, 32'h00000080);
        // SH 0x202, MMU answers in the 5th ACCESS cycle.
        run_op(1'b1, 3'b001, 32'h202, 32'h0000ABCD, 5, 0);
        check("lit_sh_din", seen_din, 32'hABCDABCD);
        check("lit_sh_bsel", 32'(seen_bsel), 32'h0000000C);
        check("lit_sh_stall", stall_count, 6);
        check("lit_sh_wen", 32'(seen_wen), 1);
        // LW 0x101 misaligned.
        run_op(1'b0, 3'b010, 32'h101, 0, 1, 0);
        check("lit_mis_cause", 32'(seen_cause), 4);
        check("lit_mis_addr", seen_exc_addr, 32'h101);
        check("lit_mis_noren", 32'(seen_ren), 0);
        check("lit_mis_nostall", stall_count, 0);
        // Halfword loads at both halves, byte store, more exceptions.
        run_op(1'b0, 3'b001, 32'h206, 0, 2, 32'h87654321);
        check("lit_lh_data", load_data, 32'hFFFF8765);
        run_op(1'b0, 3'b101, 32'h200, 0, 3, 32'h87654321);
        run_op(1'b1, 3'b000, 32'h301, 32'h123456A5, 1, 0);
        check("lit_sb_din", seen_din, 32'hA5A5A5A5);
        run_op(1'b0, 3'b011, 32'h400, 0, 1, 0);
        run_op(1'b1, 3'b100, 32'h404, 0, 1, 0);
        run_op(1'b1, 3'b001, 32'h203, 0, 1, 0);
        run_op(1'b1, 3'b010, 32'h206, 0, 1, 0);
        // Neither read nor write: nothing happens.
        @(posedge clk); #1;
        mem_valid = 1; mem_read = 0; mem_write = 0; funct3 = 3'b010; addr = 32'h10;
        set_quiet();
        @(posedge clk); #1;
        mem_valid = 0;
        // MMU answers on the last allowed cycle: success, not fault.
        run_op(1'b0, 3'b010, 32'h500, 0, T, 32'h13579BDF);
        // Watchdog: store and load never answered.
        run_op(1'b1, 3'b010, 32'h600, 32'h11223344, -1, 0);
        check("lit_to_cause", 32'(seen_cause), 7);
        check("lit_to_stall", stall_count, T + 1);
        run_op(1'b0, 3'b000, 32'h604, 0, -1, 0);
        check("lit_to_ld_keep", load_data, 32'h13579BDF);

        // Reset in the middle of ACCESS, then a normal load.
        @(posedge clk); #1;
        mem_valid = 1; mem_write = 1; funct3 = 3'b010; addr = 32'h300; store_data = 32'hCAFEF00D;
        set_quiet(); exp_stall = 1;
        @(posedge clk); #1;
        set_quiet(); exp_stall = 1; exp_wen = 1;
        chk_mmu = 1; exp_mmu_addr = 32'h300; exp_bsel = 4'hF; chk_din = 1; exp_din = 32'hCAFEF00D;
        @(posedge clk); #2;
        reset = 1; mem_valid = 0; mem_write = 0;
        last_load = 0; set_quiet();
        @(posedge clk); #1;
        reset = 0;
        run_op(1'b0, 3'b010, 32'h40, 0, 1, 32'h0BADF00D);
        check("lit_post_rst", load_data, 32'h0BADF00D);

        @(posedge clk); #1;
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
